activation_scheduler: RTL and testbench
=======================================

Name: activation_scheduler

Overview:
- Sequencing controller for the spiking activation unit: runs one inference window of N timesteps across NUM_COLUMNS activation elements.
- Owns the per-column threshold registers and clears the spike accumulators at window start.
- Issues one fire-enable per timestep once the array delivers membrane potentials, then streams the per-column accumulated spike counts out over a valid/ready port.
- Sits between the systolic array output and the next layer/host buffer.

Parameters:
- NUM_COLUMNS, 3, number of activation elements controlled.
- DATA_WIDTH, 16, threshold / membrane potential width.
- TIMER_WIDTH, 5, timestep counter and spike-count width.
- THRESH_RESET, 16'sd256, reset value of every threshold register.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_we  in  1  threshold write strobe.
- cfg_addr  in  $clog2(NUM_COLUMNS)  column index for the write.
- cfg_data  in  DATA_WIDTH  signed threshold value.
- cfg_err  out  1  one-cycle pulse: write rejected.
- start  in  1  begin window (sampled only in IDLE).
- num_timesteps  in  TIMER_WIDTH  window length N, sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the window completes.
- mp_valid  in  1  membrane potentials for the current timestep are valid.
- mp_ready  out  1  scheduler accepts a timestep.
- ts_index  out  TIMER_WIDTH  current timestep, 0..N-1.
- act_clear  out  1  clear all spike accumulators.
- act_en  out  1  threshold-compare/accumulate enable to all elements.
- threshold_bus  out  NUM_COLUMNS*DATA_WIDTH  thresholds, column 0 in the LSBs.
- spikes_in  in  NUM_COLUMNS*TIMER_WIDTH  accumulated spike counts from the elements.
- out_valid  out  1  readout word valid.
- out_ready  in  1  downstream accepts the word.
- out_col  out  $clog2(NUM_COLUMNS)  column of out_spikes.
- out_spikes  out  TIMER_WIDTH  spike count for out_col.

Behaviour:
- Reset (sync, rst=1 at clk edge), applies in any state including mid-window:
  - state=IDLE.
  - All thresholds = THRESH_RESET.
  - busy, done, mp_ready, act_clear, act_en, out_valid, cfg_err = 0.
  - ts_index, out_col, out_spikes, snapshot = 0.
- Config writes:
  - Accepted only in IDLE with cfg_addr < NUM_COLUMNS; the register updates on the next edge and threshold_bus reflects it the cycle after cfg_we.
  - A write while busy or with an out-of-range address is dropped, and cfg_err=1 the following cycle.
  - threshold_bus is stable for the whole window.
- IDLE: start=1 latches N=num_timesteps and moves to CLEAR. start in any other state is ignored.
- CLEAR: act_clear=1 for exactly one cycle; ts_index=0.
  - N==0: go to SETTLE (the readout is all zeros).
  - Otherwise: go to WAIT.
- WAIT: mp_ready=1. When mp_valid&&mp_ready, go to FIRE. mp_valid may stall indefinitely.
- FIRE: act_en=1 for exactly one cycle; mp_ready=0.
  - ts_index==N-1: go to SETTLE.
  - Otherwise: ts_index+1, back to WAIT.
  - Minimum 2 cycles per timestep.
- SETTLE: one cycle so the accumulators register the final act_en. At the end of the cycle, capture spikes_in into the snapshot register; out_col=0; go to READOUT.
- READOUT:
  - out_valid=1; out_spikes = snapshot[out_col]; out_col and out_spikes are held stable while out_ready=0.
  - On out_valid&&out_ready: if out_col==NUM_COLUMNS-1, go to DONE; otherwise out_col+1.
  - Back-to-back acceptance gives 1 word/cycle.
- DONE: done=1 for one cycle, busy=0 from the next cycle, go to IDLE. A start on the cycle after done begins a new window.
- Width rules:
  - N ≤ 2^TIMER_WIDTH-1, so counts cannot overflow; no saturation logic is needed here.
  - Threshold registers are signed and stored verbatim.

Decomposition:
- Shared package (snn_pkg):
  - state enum {IDLE, CLEAR, WAIT, FIRE, SETTLE, READOUT, DONE}.
  - Default DATA_WIDTH/TIMER_WIDTH constants.
  - THRESH_RESET constant.
- One natural sub-module: threshold_regfile. It holds the NUM_COLUMNS write-port registers, performs the address-range and lock check, generates cfg_err, and drives threshold_bus.
- The FSM, ts_index counter, snapshot and readout mux stay in activation_scheduler.

Test Plan:
- Reset then IDLE write cfg_addr=1, cfg_data=-5 → threshold_bus[31:16]=16'hFFFB, other lanes 16'h0100, cfg_err=0.
- start, N=3, mp_valid always 1 → act_clear 1 cycle; act_en on exactly 3 cycles with ts_index 0,1,2; spikes_in={5'd2,5'd3,5'd1} → out words (col0=1, col1=3, col2=2); done 1 cycle; total window 1+3×2+1+3+1 cycles.
- N=4, mp_valid held low for 5 cycles before timestep 2 → mp_ready stays 1, no act_en during the stall, exactly 4 act_en pulses total.
- READOUT with out_ready low 3 cycles on col1 → out_col=1 and out_spikes are stable throughout; spikes_in changes after SETTLE do not alter the output.
- N=0 → act_clear, no act_en, readout emits all three words as 0, then done.
- cfg_we while busy, or with cfg_addr=3 → threshold unchanged, cfg_err pulse. rst asserted in FIRE → next cycle IDLE, all outputs 0, thresholds = THRESH_RESET; a following start runs a clean window.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking activation unit: scheduler states and
// default widths / reset values.
package snn_pkg;

  localparam int DATA_WIDTH_DEF  = 16;
  localparam int TIMER_WIDTH_DEF = 5;

  localparam logic signed [DATA_WIDTH_DEF-1:0] THRESH_RESET_DEF = 16'sd256;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT,
    FIRE,
    SETTLE,
    READOUT,
    DONE
  } state_t;

endpackage

// File: rtl/threshold_regfile.sv
// Per-column signed threshold registers with a locked, range-checked write port.
// Rejected writes raise a one-cycle error pulse on the following cycle.
module threshold_regfile
  import snn_pkg::*;
#(
  parameter int                              NUM_COLUMNS  = 3,
  parameter int                              DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter logic signed [DATA_WIDTH-1:0]    THRESH_RESET = DATA_WIDTH'(THRESH_RESET_DEF)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              lock,
  input  logic                              cfg_we,
  input  logic [$clog2(NUM_COLUMNS)-1:0]    cfg_addr,
  input  logic signed [DATA_WIDTH-1:0]      cfg_data,
  output logic                              cfg_err,
  output logic [NUM_COLUMNS*DATA_WIDTH-1:0] threshold_bus
);

  logic signed [DATA_WIDTH-1:0] r_thresh [NUM_COLUMNS];
  logic                         r_cfg_err;
  logic                         w_addr_ok;
  logic                         w_wr_en;
  logic                         w_reject;

  assign w_addr_ok = int'(cfg_addr) < NUM_COLUMNS;
  assign w_wr_en   = cfg_we && !lock && w_addr_ok;
  assign w_reject  = cfg_we && (lock || !w_addr_ok);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_err <= 1'b0;
      // NOTE: this register array is reset explicitly because the thresholds
      // must come up at a defined value; plain storage arrays are not reset.
      for (int i = 0; i < NUM_COLUMNS; i++) begin
        r_thresh[i] <= THRESH_RESET;
      end
    end else begin
      r_cfg_err <= w_reject;
      for (int i = 0; i < NUM_COLUMNS; i++) begin
        if (w_wr_en && int'(cfg_addr) == i) begin
          r_thresh[i] <= cfg_data;
        end
      end
    end
  end

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    threshold_bus = '0;
    for (int i = 0; i < NUM_COLUMNS; i++) begin
      threshold_bus[i*DATA_WIDTH +: DATA_WIDTH] = r_thresh[i];
    end
  end

  assign cfg_err = r_cfg_err;

endmodule

// File: rtl/activation_scheduler.sv
// Window sequencer for the spiking activation unit: clears accumulators, issues one
// fire-enable per accepted timestep, then streams the captured spike counts out.
module activation_scheduler
  import snn_pkg::*;
#(
  parameter int                           NUM_COLUMNS  = 3,
  parameter int                           DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int                           TIMER_WIDTH  = TIMER_WIDTH_DEF,
  parameter logic signed [DATA_WIDTH-1:0] THRESH_RESET = DATA_WIDTH'(THRESH_RESET_DEF)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_we,
  input  logic [$clog2(NUM_COLUMNS)-1:0]     cfg_addr,
  input  logic signed [DATA_WIDTH-1:0]       cfg_data,
  output logic                               cfg_err,
  input  logic                               start,
  input  logic [TIMER_WIDTH-1:0]             num_timesteps,
  output logic                               busy,
  output logic                               done,
  input  logic                               mp_valid,
  output logic                               mp_ready,
  output logic [TIMER_WIDTH-1:0]             ts_index,
  output logic                               act_clear,
  output logic                               act_en,
  output logic [NUM_COLUMNS*DATA_WIDTH-1:0]  threshold_bus,
  input  logic [NUM_COLUMNS*TIMER_WIDTH-1:0] spikes_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [$clog2(NUM_COLUMNS)-1:0]     out_col,
  output logic [TIMER_WIDTH-1:0]             out_spikes
);

  localparam int                CW       = $clog2(NUM_COLUMNS);
  localparam logic [CW-1:0]     LAST_COL = CW'(NUM_COLUMNS - 1);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [TIMER_WIDTH-1:0]  r_num_ts;
  logic [TIMER_WIDTH-1:0]  r_ts_index;
  logic [CW-1:0]           r_out_col;
  logic [TIMER_WIDTH-1:0]  r_snapshot [NUM_COLUMNS];
  logic [TIMER_WIDTH-1:0]  w_out_spikes;
  logic                    w_last_ts;
  logic                    w_last_col;

  assign w_last_ts  = (r_ts_index == r_num_ts - TIMER_WIDTH'(1));
  assign w_last_col = (r_out_col == LAST_COL);

  threshold_regfile #(
    .NUM_COLUMNS  (NUM_COLUMNS),
    .DATA_WIDTH   (DATA_WIDTH),
    .THRESH_RESET (THRESH_RESET)
  ) u_threshold_regfile (
    .clk           (clk),
    .rst           (rst),
    .lock          (busy),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .cfg_err       (cfg_err),
    .threshold_bus (threshold_bus)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next_state = CLEAR;
      CLEAR:   w_next_state = (r_num_ts == '0) ? SETTLE : WAIT;
      WAIT:    if (mp_valid) w_next_state = FIRE;
      FIRE:    w_next_state = w_last_ts ? SETTLE : WAIT;
      SETTLE:  w_next_state = READOUT;
      READOUT: if (out_ready && w_last_col) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: window length, timestep counter, readout pointer and snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num_ts   <= '0;
      r_ts_index <= '0;
      r_out_col  <= '0;
      for (int i = 0; i < NUM_COLUMNS; i++) begin
        r_snapshot[i] <= '0;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_num_ts   <= num_timesteps;
            r_ts_index <= '0;
          end
        end
        FIRE: begin
          if (!w_last_ts) begin
            r_ts_index <= r_ts_index + TIMER_WIDTH'(1);
          end
        end
        SETTLE: begin
          r_out_col <= '0;
          for (int i = 0; i < NUM_COLUMNS; i++) begin
            r_snapshot[i] <= spikes_in[i*TIMER_WIDTH +: TIMER_WIDTH];
          end
        end
        READOUT: begin
          if (out_ready && !w_last_col) begin
            r_out_col <= r_out_col + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_out_spikes = '0;
    for (int i = 0; i < NUM_COLUMNS; i++) begin
      if (int'(r_out_col) == i) begin
        w_out_spikes = r_snapshot[i];
      end
    end
  end

  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);
  assign mp_ready   = (r_state == WAIT);
  assign act_clear  = (r_state == CLEAR);
  assign act_en     = (r_state == FIRE);
  assign out_valid  = (r_state == READOUT);
  assign ts_index   = r_ts_index;
  assign out_col    = r_out_col;
  assign out_spikes = w_out_spikes;

endmodule

// File: tb/tb_activation_scheduler.sv
// Directed bench for activation_scheduler: a transaction-level scoreboard
// (thresholds, expected timesteps, expected readout words) checked every cycle.
module tb_activation_scheduler;

  localparam int NC = 3;
  localparam int DW = 16;
  localparam int TW = 5;
  localparam int CW = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cfg_we;
  logic [CW-1:0]          cfg_addr;
  logic signed [DW-1:0]   cfg_data;
  logic                   cfg_err;
  logic                   start;
  logic [TW-1:0]          num_timesteps;
  logic                   busy;
  logic                   done;
  logic                   mp_valid;
  logic                   mp_ready;
  logic [TW-1:0]          ts_index;
  logic                   act_clear;
  logic                   act_en;
  logic [NC*DW-1:0]       threshold_bus;
  logic [NC*TW-1:0]       spikes_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [CW-1:0]          out_col;
  logic [TW-1:0]          out_spikes;

  always #5 clk = ~clk;

  activation_scheduler #(
    .NUM_COLUMNS (NC),
    .DATA_WIDTH  (DW),
    .TIMER_WIDTH (TW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .cfg_err       (cfg_err),
    .start         (start),
    .num_timesteps (num_timesteps),
    .busy          (busy),
    .done          (done),
    .mp_valid      (mp_valid),
    .mp_ready      (mp_ready),
    .ts_index      (ts_index),
    .act_clear     (act_clear),
    .act_en        (act_en),
    .threshold_bus (threshold_bus),
    .spikes_in     (spikes_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_col       (out_col),
    .out_spikes    (out_spikes)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard state
  typedef struct {
    int col;
    int val;
  } word_t;

  logic signed [DW-1:0] m_thr [NC];
  int                   exp_ts[$];
  word_t                exp_words[$];
  logic                 exp_err = 1'b0;
  bit                   mon_en  = 1'b0;
  logic                 prev_stall = 1'b0;
  int                   got[NC];

  function automatic logic [NC*DW-1:0] m_bus();
    logic [NC*DW-1:0] b;
    b = '0;
    for (int i = 0; i < NC; i++) b[i*DW +: DW] = m_thr[i];
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) m_thr[i] = 16'sd256;
    exp_ts.delete();
    exp_words.delete();
    exp_err = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      word_t w;
      check("threshold_bus", threshold_bus, m_bus());
      check("cfg_err", cfg_err, exp_err);
      if (prev_stall) check("stall_no_fire", {act_en, mp_ready}, 2'b01);
      if (act_en) begin
        if (exp_ts.size() == 0) check("act_en_unexpected", act_en, 0);
        else check("ts_index", ts_index, exp_ts.pop_front());
      end
      if (out_valid) begin
        if (exp_words.size() == 0) begin
          check("out_valid_unexpected", out_valid, 0);
        end else begin
          w = exp_words[0];
          check("out_col", out_col, w.col);
          check("out_spikes", out_spikes, w.val);
          if (out_ready) void'(exp_words.pop_front());
        end
      end
      prev_stall <= mp_ready && !mp_valid;
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_busy"},       busy, 0);
    check({tag, "_done"},       done, 0);
    check({tag, "_mp_ready"},   mp_ready, 0);
    check({tag, "_act_clear"},  act_clear, 0);
    check({tag, "_act_en"},     act_en, 0);
    check({tag, "_out_valid"},  out_valid, 0);
    check({tag, "_cfg_err"},    cfg_err, 0);
    check({tag, "_ts_index"},   ts_index, 0);
    check({tag, "_out_col"},    out_col, 0);
    check({tag, "_out_spikes"}, out_spikes, 0);
    check({tag, "_thr_bus"},    threshold_bus, 48'h0100_0100_0100);
  endtask

  // Called at posedge+1 while the DUT is idle.
  task automatic cfg_write(input int addr, input logic signed [DW-1:0] data, input bit accept);
    cfg_we   = 1'b1;
    cfg_addr = addr[CW-1:0];
    cfg_data = data;
    @(posedge clk); #1;
    cfg_we  = 1'b0;
    exp_err = !accept;
    if (accept) m_thr[addr] = data;
    @(posedge clk); #1;
    exp_err = 1'b0;
  endtask

  // One full window; stall_at/ro_col/wr_cyc of -1 disable that disturbance.
  task automatic run_window(input int n, input logic [NC*TW-1:0] spk,
                            input int stall_at, input int stall_len,
                            input int ro_col, input int ro_len,
                            input int wr_cyc, input int exp_busy);
    int  act_seen, clr, dn, busy_cnt, acc, stall_left, ro_left;
    bit  ok;
    logic [NC*TW-1:0] sh;
    for (int t = 0; t < n; t++) exp_ts.push_back(t);
    for (int c = 0; c < NC; c++) begin
      sh = spk >> (c * TW);
      exp_words.push_back('{c, int'(sh[TW-1:0])});
    end
    spikes_in     = spk;
    mp_valid      = 1'b1;
    out_ready     = 1'b1;
    start         = 1'b1;
    num_timesteps = n[TW-1:0];
    @(posedge clk); #1;
    start = 1'b0;
    act_seen = 0; clr = 0; dn = 0; busy_cnt = 0; acc = 0;
    stall_left = stall_len; ro_left = ro_len; ok = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (mp_ready && act_seen == stall_at && stall_left > 0) begin
        mp_valid = 1'b0;
        stall_left--;
      end else begin
        mp_valid = 1'b1;
      end
      if (out_valid && int'(out_col) == ro_col && ro_left > 0) begin
        out_ready = 1'b0;
        ro_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid) spikes_in = ~spk;
      cfg_we = (cyc == wr_cyc);
      if (cfg_we) begin
        cfg_addr = '0;
        cfg_data = 16'sh1234;
      end
      exp_err = (wr_cyc >= 0) && (cyc == wr_cyc + 1);
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      busy_cnt++;
      act_seen += int'(act_en);
      clr      += int'(act_clear);
      dn       += int'(done);
      if (out_valid && out_ready && acc < NC) begin
        got[acc] = int'(out_spikes);
        acc++;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cfg_we  = 1'b0;
    exp_err = 1'b0;
    if (!ok) check("window_timeout", busy, 0);
    check("window_cycles", busy_cnt, exp_busy);
    check("act_en_count", act_seen, n);
    check("act_clear_count", clr, 1);
    check("done_count", dn, 1);
    check("words_accepted", acc, NC);
    check("ts_queue_drained", exp_ts.size(), 0);
    check("word_queue_drained", exp_words.size(), 0);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; num_timesteps = '0; mp_valid = 1'b0;
    spikes_in = '0; out_ready = 1'b0;
    for (int i = 0; i < NC; i++) got[i] = -1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;

    // Threshold write in IDLE: column 1 = -5
    cfg_write(1, -16'sd5, 1'b1);
    @(negedge clk);
    check("bus_after_write", threshold_bus, 48'h0100_FFFB_0100);
    check("err_after_write", cfg_err, 0);
    @(posedge clk); #1;

    // N=3, no stalls: 1 + 3*2 + 1 + 3 + 1 = 12 busy cycles
    run_window(3, {5'd2, 5'd3, 5'd1}, -1, 0, -1, 0, -1, 12);
    check("w1_col0", got[0], 1);
    check("w1_col1", got[1], 3);
    check("w1_col2", got[2], 2);

    // N=4, 5-cycle stall before timestep 2, write attempt while busy
    run_window(4, {5'd4, 5'd0, 5'd4}, 2, 5, -1, 0, 3, 19);

    // N=3, out_ready low for 3 cycles on column 1, spikes_in changes after SETTLE
    run_window(3, {5'd7, 5'd9, 5'd31}, -1, 0, 1, 3, -1, 15);
    check("w3_col2_max", got[2], 7);

    // N=0: clear, settle, three zero words, done
    run_window(0, '0, -1, 0, -1, 0, -1, 6);

    // Out-of-range address rejected; most-negative threshold stored verbatim
    cfg_write(3, 16'sh7777, 1'b0);
    cfg_write(2, 16'sh8000, 1'b1);
    @(negedge clk);
    check("bus_after_min", threshold_bus, 48'h8000_FFFB_0100);
    @(posedge clk); #1;

    // Reset asserted while in FIRE
    exp_ts.push_back(0); exp_ts.push_back(1); exp_ts.push_back(2);
    spikes_in     = {5'd1, 5'd1, 5'd1};
    mp_valid      = 1'b1;
    out_ready     = 1'b1;
    start         = 1'b1;
    num_timesteps = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (act_en) break;
      @(posedge clk); #1;
    end
    check("reached_fire", act_en, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_idle("midreset");
    @(posedge clk); #1;

    // Clean window after reset: 1 + 2*2 + 1 + 3 + 1 = 10
    run_window(2, {5'd2, 5'd1, 5'd0}, -1, 0, -1, 0, -1, 10);
    check("w5_col1", got[1], 1);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
